// File: rtl/glb_tile_st_dma_pkg.sv
// Shared types and widths for the GLB tile store-DMA.
// Header, write-packet and FSM state definitions.
package glb_tile_st_dma_pkg;

  localparam int QUEUE_DEPTH = 4;
  localparam int GLB_ADDR_WIDTH = 22;
  localparam int BANK_DATA_WIDTH = 64;
  localparam int CGRA_DATA_WIDTH = 16;
  localparam int MAX_NUM_WORDS_WIDTH = 21;
  localparam int BANK_STRB_WIDTH = BANK_DATA_WIDTH / 8;
  localparam int HDR_CNT_WIDTH = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic                           valid;
    logic [GLB_ADDR_WIDTH-1:0]      start_addr;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_words;
  } dma_st_header_t;

  typedef struct packed {
    logic                       wr_en;
    logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
    logic [BANK_STRB_WIDTH-1:0] wr_strb;
    logic [BANK_DATA_WIDTH-1:0] wr_data;
  } wr_packet_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } st_dma_state_e;

  function automatic logic [GLB_ADDR_WIDTH-1:0] line_addr(
    input logic [GLB_ADDR_WIDTH-1:0] a
  );
    return {a[GLB_ADDR_WIDTH-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/glb_tile_st_dma_if.sv
// Stream-in / packet-out bundle of the store-DMA.
// Master is the CGRA/arbiter side, slave is the DMA.
interface glb_tile_st_dma_if;
  import glb_tile_st_dma_pkg::*;

  logic [CGRA_DATA_WIDTH-1:0] strm_data_f2g;
  logic                       strm_valid_f2g;
  wr_packet_t                 wr_packet;

  modport master (
    output strm_data_f2g,
    output strm_valid_f2g,
    input  wr_packet
  );

  modport slave (
    input  strm_data_f2g,
    input  strm_valid_f2g,
    output wr_packet
  );

endinterface

// File: rtl/glb_hdr_fifo.sv
// Synchronous header FIFO with count/full/empty.
// Push while full and pop while empty are ignored.
module glb_hdr_fifo
  import glb_tile_st_dma_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           push,
  input  dma_st_header_t din,
  input  logic           pop,
  output dma_st_header_t dout,
  output logic [CW-1:0]  count,
  output logic           full,
  output logic           empty
);

  dma_st_header_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/glb_tile_st_dma.sv
// GLB tile store-DMA: header queue + 16-to-64 bit
// packing into byte-strobed bank write packets.
module glb_tile_st_dma
  import glb_tile_st_dma_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     st_dma_en,
  input  logic                     hdr_push,
  input  dma_st_header_t           cfg_hdr,
  output logic                     hdr_full,
  output logic [HDR_CNT_WIDTH-1:0] hdr_count,
  glb_tile_st_dma_if.slave         strm,
  output logic                     st_dma_busy,
  output logic                     st_dma_done_pulse
);

  st_dma_state_e state_q, state_d;

  logic [GLB_ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [MAX_NUM_WORDS_WIDTH-1:0] words_q, words_d;
  logic [BANK_DATA_WIDTH-1:0]     line_q, line_d, line_w;
  logic [BANK_STRB_WIDTH-1:0]     strb_q, strb_d, strb_w;
  wr_packet_t                     pkt_q, pkt_d;
  logic [1:0]                     lane;
  logic                           pop;
  logic                           empty;
  dma_st_header_t                 head;
  logic                           unused_hdr_bits;

  assign unused_hdr_bits = ^{head.valid, head.start_addr[0]};

  glb_hdr_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_hdr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (hdr_push && cfg_hdr.valid),
    .din     (cfg_hdr),
    .pop     (pop),
    .dout    (head),
    .count   (hdr_count),
    .full    (hdr_full),
    .empty   (empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    line_d  = line_q;
    strb_d  = strb_q;
    pkt_d   = '0;
    pop     = 1'b0;
    lane    = addr_q[2:1];
    line_w  = line_q;
    strb_w  = strb_q;
    unique case (state_q)
      IDLE: begin
        if (st_dma_en && !empty) begin
          pop     = 1'b1;
          addr_d  = {head.start_addr[GLB_ADDR_WIDTH-1:1], 1'b0};
          words_d = head.num_words;
          line_d  = '0;
          strb_d  = '0;
          state_d = (head.num_words == '0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (words_q == '0) begin
          state_d = DONE;
        end else if (strm.strm_valid_f2g) begin
          line_w[{lane, 4'b0000} +: CGRA_DATA_WIDTH] = strm.strm_data_f2g;
          strb_w[{lane, 1'b0} +: 2] = 2'b11;
          // Close the line on the top lane or the final word
          if (lane == 2'd3 || words_q == MAX_NUM_WORDS_WIDTH'(1)) begin
            pkt_d.wr_en   = 1'b1;
            pkt_d.wr_addr = line_addr(addr_q);
            pkt_d.wr_strb = strb_w;
            pkt_d.wr_data = line_w;
            line_d = '0;
            strb_d = '0;
          end else begin
            line_d = line_w;
            strb_d = strb_w;
          end
          addr_d  = addr_q + GLB_ADDR_WIDTH'(2);
          words_d = words_q - MAX_NUM_WORDS_WIDTH'(1);
          if (words_q == MAX_NUM_WORDS_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      words_q <= '0;
      line_q  <= '0;
      strb_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      line_q  <= line_d;
      strb_q  <= strb_d;
      pkt_q   <= pkt_d;
    end
  end

  assign strm.wr_packet    = pkt_q;
  assign st_dma_busy       = (state_q != IDLE);
  assign st_dma_done_pulse = (state_q == DONE);

endmodule

// File: tb/tb_glb_tile_st_dma.sv
// Bench for glb_tile_st_dma: per-cycle model compare
// plus literal packet expectations for each scenario.
module tb_glb_tile_st_dma;
  import glb_tile_st_dma_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     en;
  logic                     hdr_push;
  dma_st_header_t           cfg_hdr;
  logic                     hdr_full;
  logic [HDR_CNT_WIDTH-1:0] hdr_count;
  logic                     busy;
  logic                     done;

  glb_tile_st_dma_if bus();

  always #5 clk = ~clk;

  glb_tile_st_dma dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .st_dma_en         (en),
    .hdr_push          (hdr_push),
    .cfg_hdr           (cfg_hdr),
    .hdr_full          (hdr_full),
    .hdr_count         (hdr_count),
    .strm              (bus),
    .st_dma_busy       (busy),
    .st_dma_done_pulse (done)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_done = 0;
  bit chk_on = 0;
  wr_packet_t dut_log[$];

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Behavioural model: header list, words left, bytes of the open line
  dma_st_header_t mq[$];
  int             m_phase;
  logic [21:0]    m_addr;
  int             m_left;
  logic [15:0]    m_line[4];
  logic [3:0]     m_have;
  wr_packet_t     e_pkt;
  logic           e_busy, e_done;
  int             e_count;

  always @(posedge clk or negedge reset_n) begin
    bit             can_push;
    dma_st_header_t h;
    int             ln;
    if (!reset_n) begin
      mq.delete();
      m_phase = 0; m_have = '0; m_addr = '0; m_left = 0;
      e_pkt = '0; e_busy = 0; e_done = 0; e_count = 0;
    end else begin
      can_push = (mq.size() < QUEUE_DEPTH);
      e_pkt = '0;
      if (m_phase == 0) begin
        if (en && mq.size() > 0) begin
          h = mq.pop_front();
          m_addr = {h.start_addr[21:1], 1'b0};
          m_left = int'(h.num_words);
          m_have = '0;
          m_phase = (m_left == 0) ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        if (bus.strm_valid_f2g) begin
          ln = int'(m_addr[2:1]);
          m_line[ln] = bus.strm_data_f2g;
          m_have[ln] = 1'b1;
          if (ln == 3 || m_left == 1) begin
            e_pkt.wr_en = 1'b1;
            e_pkt.wr_addr = m_addr & ~22'h7;
            for (int k = 0; k < 4; k++) begin
              if (m_have[k]) begin
                e_pkt.wr_data[k*16 +: 16] = m_line[k];
                e_pkt.wr_strb[k*2 +: 2] = 2'b11;
              end
            end
            m_have = '0;
          end
          m_addr = m_addr + 22'd2;
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
      if (hdr_push && cfg_hdr.valid && can_push) mq.push_back(cfg_hdr);
      e_busy = (m_phase != 0);
      e_done = (m_phase == 2);
      e_count = mq.size();
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_on) begin
      check("pkt", bus.wr_packet, e_pkt);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("count", hdr_count, e_count);
      check("full", hdr_full, e_count == QUEUE_DEPTH);
      if (bus.wr_packet.wr_en) dut_log.push_back(bus.wr_packet);
      if (done) n_done++;
    end
  end

  task automatic push_hdr(input logic [21:0] s, input logic [20:0] n);
    @(negedge clk);
    hdr_push = 1'b1;
    cfg_hdr = '{valid: 1'b1, start_addr: s, num_words: n};
    @(negedge clk);
    hdr_push = 1'b0;
    cfg_hdr = '0;
  endtask

  task automatic stream(input int n, input logic [15:0] base,
                        input logic [15:0] step, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.strm_valid_f2g = 1'b1;
      bus.strm_data_f2g = base + 16'(i) * step;
      repeat (gap) begin
        @(negedge clk);
        bus.strm_valid_f2g = 1'b0;
      end
    end
    @(negedge clk);
    bus.strm_valid_f2g = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_pkt(input string nm, input int idx, input logic [21:0] a,
                         input logic [7:0] s, input logic [63:0] d);
    wr_packet_t p;
    p = '{wr_en: 1'b1, wr_addr: a, wr_strb: s, wr_data: d};
    if (dut_log.size() > idx) check(nm, dut_log[idx], p);
    else check({nm, "_missing"}, dut_log.size(), idx + 1);
  endtask

  task automatic clear_log();
    dut_log.delete();
    n_done = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    hdr_push = 1'b0;
    cfg_hdr = '0;
    bus.strm_valid_f2g = 1'b0;
    bus.strm_data_f2g = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_pkt", bus.wr_packet, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", hdr_count, 0);
    check("rst_full", hdr_full, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    chk_on = 1;
    en = 1'b1;

    // aligned full line
    clear_log();
    push_hdr(22'h100, 21'd4);
    stream(4, 16'h1111, 16'h1111, 0);
    idle(4);
    check("t1_npkt", dut_log.size(), 1);
    chk_pkt("t1_pkt", 0, 22'h100, 8'hFF, 64'h4444_3333_2222_1111);
    check("t1_done", n_done, 1);

    // unaligned partial
    clear_log();
    push_hdr(22'h104, 21'd3);
    stream(3, 16'h000A, 16'h0001, 0);
    idle(4);
    check("t2_npkt", dut_log.size(), 2);
    chk_pkt("t2_pkt0", 0, 22'h100, 8'hF0, 64'h000B_000A_0000_0000);
    chk_pkt("t2_pkt1", 1, 22'h108, 8'h03, 64'h0000_0000_0000_000C);
    check("t2_done", n_done, 1);

    // zero length
    clear_log();
    push_hdr(22'h200, 21'd0);
    idle(4);
    check("t4_npkt", dut_log.size(), 0);
    check("t4_done", n_done, 1);

    // gapped stream
    clear_log();
    push_hdr(22'h300, 21'd2);
    stream(2, 16'h5555, 16'h1111, 3);
    idle(4);
    check("t4b_npkt", dut_log.size(), 1);
    chk_pkt("t4b_pkt", 0, 22'h300, 8'h0F, 64'h0000_0000_6666_5555);
    check("t4b_done", n_done, 1);

    // address wrap
    clear_log();
    push_hdr(22'h3FFFFC, 21'd3);
    stream(3, 16'h0001, 16'h0001, 0);
    idle(4);
    check("t5_npkt", dut_log.size(), 2);
    chk_pkt("t5_pkt0", 0, 22'h3FFFF8, 8'hF0, 64'h0002_0001_0000_0000);
    chk_pkt("t5_pkt1", 1, 22'h000000, 8'h03, 64'h0000_0000_0000_0003);

    // queue full, then drain in push order
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) push_hdr(22'h1000 + 22'(8 * i), 21'd1);
    @(negedge clk);
    #1;
    check("t3_count", hdr_count, 4);
    check("t3_full", hdr_full, 1'b1);
    clear_log();
    @(negedge clk);
    en = 1'b1;
    stream(24, 16'h0100, 16'h0001, 0);
    idle(4);
    check("t3_npkt", dut_log.size(), 4);
    check("t3_done", n_done, 4);
    for (int i = 0; i < 4; i++) begin
      if (dut_log.size() > i) begin
        check($sformatf("t3_addr%0d", i), dut_log[i].wr_addr,
              22'h1000 + 22'(8 * i));
        check($sformatf("t3_strb%0d", i), dut_log[i].wr_strb, 8'h03);
      end
    end

    // reset mid-transfer
    push_hdr(22'h500, 21'd4);
    push_hdr(22'h600, 21'd1);
    stream(2, 16'h7777, 16'h0001, 0);
    #2 reset_n = 1'b0;
    #1;
    check("t6_pkt", bus.wr_packet, '0);
    check("t6_busy", busy, 1'b0);
    check("t6_count", hdr_count, 0);
    check("t6_full", hdr_full, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    clear_log();
    stream(2, 16'h9999, 16'h0001, 0);
    idle(6);
    check("t6_npkt", dut_log.size(), 0);
    check("t6_done", n_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/glb_tile_st_dma.md
Name: glb_tile_st_dma

Overview:
- Store-DMA controller for one GLB tile. Sequences queued store headers (dma_st_header_t) and turns the incoming 16-bit CGRA stream into 64-bit byte-strobed SRAM write packets (wr_packet_t) aimed at the tile's banks.
- Sits between the tile's config registers (header push) and the tile's bank write arbiter.
- Owns the header queue, the word counter, the address counter and the 16-to-64 packing.

Parameters:
- QUEUE_DEPTH, 4 (package default): header queue entries.
- GLB_ADDR_WIDTH, 22 (package): byte address width.
- BANK_DATA_WIDTH, 64 (package): packed write width.
- CGRA_DATA_WIDTH, 16 (package): stream word width.
- MAX_NUM_WORDS_WIDTH, 21 (package): word-count width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- st_dma_en  in  1  enables starting a new header
- hdr_push  in  1  push cfg_hdr into the queue
- cfg_hdr  in  dma_st_header_t  header to push
- hdr_full  out  1  queue holds QUEUE_DEPTH entries
- hdr_count  out  $clog2(QUEUE_DEPTH)+1  entries queued
- strm_data_f2g  in  CGRA_DATA_WIDTH  stream word from CGRA
- strm_valid_f2g  in  1  stream word valid
- wr_packet  out  wr_packet_t  registered write packet to bank arbiter
- st_dma_busy  out  1  FSM not IDLE
- st_dma_done_pulse  out  1  one-cycle pulse per completed header

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: wr_packet all zero; st_dma_done_pulse=0; st_dma_busy=0; hdr_full=0; hdr_count=0. The queue, counters and packing buffer are cleared.
- Reset mid-operation discards all queued headers and any partial line. No packet is emitted.
- Queue push: accepted when hdr_push=1, cfg_hdr.valid=1 and the queue is not full at the start of the cycle.
  - A push while hdr_full is dropped, even if a pop happens in the same cycle.
  - A push with valid=0 is ignored.
- Queue pop: occurs on the IDLE->ACTIVE transition. Simultaneous push and pop leaves hdr_count unchanged.
- FSM states:
  - IDLE: go to ACTIVE when st_dma_en=1 and hdr_count>0. Latch the head header into addr_q=start_addr and words_left=num_words, then pop.
  - ACTIVE: each cycle with strm_valid_f2g=1 consumes one word.
    - Word goes to lane addr_q[2:1] of the line buffer; strobe bits [2*lane+1:2*lane] are set.
    - addr_q += 2, modulo 2^GLB_ADDR_WIDTH; words_left -= 1.
    - Emit a line when lane==3 or words_left==1.
    - After the last word (words_left reaches 0), go to DONE.
    - If the header num_words==0, go to DONE immediately with no writes.
  - DONE: st_dma_done_pulse=1 for exactly this cycle, then return to IDLE.
- st_dma_en deasserted in ACTIVE does not abort the transfer; it only blocks the next start.
- Stream words arriving in IDLE or DONE are dropped.
- Packet emission (registered, 1-cycle latency after the consuming word):
  - wr_en=1; wr_addr = line address with bits [2:0]=0.
  - wr_data carries the accumulated lanes; lanes not written are 0.
  - wr_strb carries the accumulated strobes.
- The line buffer and strobes clear when a line is emitted, so the next word starts a fresh line in the same cycle.
- wr_packet.wr_en is 0 in every non-emission cycle, and the other fields are 0 then too.
- Start address: start_addr[0] is ignored (treated as 0).
- Unaligned start (addr[2:1]!=0): the first line carries only the upper lanes. Example: start lane 2 with num_words=1 gives wr_strb=8'h30.
- Address wrap: at 2^GLB_ADDR_WIDTH-2 the next word goes to address 0. A line never spans the wrap point.
- No backpressure: the downstream arbiter must accept every packet.

Decomposition:
- Shared package: the wr_packet_t and dma_st_header_t typedefs, all width constants, QUEUE_DEPTH.
- Add a package enum st_dma_state_e {IDLE, ACTIVE, DONE}.
- One natural sub-module: glb_hdr_fifo, a parameterized synchronous FIFO of dma_st_header_t with count/full/empty outputs.

Test Plan:
- Aligned full line: push hdr{start=0x100, num_words=4}, stream 0x1111,0x2222,0x3333,0x4444 back to back -> one packet: wr_addr=0x100, wr_strb=8'hFF, wr_data=64'h4444_3333_2222_1111; done pulse 1 cycle later.
- Unaligned partial: push hdr{start=0x104, num_words=3}, words A,B,C -> packet{0x100, strb=8'hF0, A in lane2, B in lane3}, then packet{0x108, strb=8'h03, C in lane0}; then done.
- Queue full: push 5 valid headers with st_dma_en=0 -> hdr_count=4, hdr_full=1, 5th dropped. Enable -> exactly 4 done pulses, headers in push order.
- Zero-length and gaps: hdr{num_words=0} -> done pulse, no wr_en. hdr{num_words=2} with valid gaps of 3 cycles -> one packet, strb=8'h0F.
- Wrap: hdr{start=2^22-4, num_words=3} -> packet{2^22-8, strb=8'hF0}, then packet{0x0, strb=8'h03}.
- Reset mid-transfer: assert reset_n=0 after 2 of 4 words -> wr_packet zero, busy=0, hdr_count=0; no packet after release.
